med_window: RTL and testbench



---
 rtl/med_pkg.sv | 20 ++
 rtl/med_line_buffer.sv | 28 ++
 rtl/med_window.sv | 163 ++++++++++++++++
 tb/tb_med_window.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/med_pkg.sv
// Shared definitions for the median filter front end: pixel width,
// window size, window FSM states and the 3x3 window container.
package med_pkg;

    localparam int PIX_W = 8;
    localparam int WIN_N = 9;

    // Index of the last window sample on the serial output.
    localparam logic [3:0] K_LAST = 4'(WIN_N - 1);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT
    } state_t;

    // Window element i is row (i / 3), column (i % 3), oldest (top-left) first.
    typedef logic [WIN_N-1:0][PIX_W-1:0] win_t;

endpackage

// File: rtl/med_line_buffer.sv
// One line of pixel storage indexed by column. The read is asynchronous, so
// the value returned is the pixel stored at this column on the previous line.
// It is overwritten on the same edge that the new pixel is accepted.
module med_line_buffer
    import med_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    addr_i,
    input  logic [PIX_W-1:0] din_i,
    output logic [PIX_W-1:0] dout_o
);

    logic [PIX_W-1:0] mem_q [DEPTH];

    // Store the incoming pixel at its column; contents need no reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= din_i;
        end
    end

    assign dout_o = mem_q[addr_i];

endmodule

// File: rtl/med_window.sv
// 3x3 neighbourhood builder for the serial median stage. Tracks the raster
// position, keeps two previous lines in line buffers, and for every interior
// pixel sends the nine window samples on DO/DSO. It then stalls the pixel
// source until the median stage reports completion on MDONE.
module med_window
    import med_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int HEIGHT = 8
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic [PIX_W-1:0] PI,
    input  logic             PSI,
    output logic             PRDY,
    input  logic             MDONE,
    output logic [PIX_W-1:0] DO,
    output logic             DSO
);

    localparam int CW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

    state_t           state_q, state_d;
    logic [3:0]       k_q, k_d;
    logic [CW-1:0]    col_q, col_d;
    logic [RW-1:0]    row_q, row_d;
    win_t             win_q, win_d;
    logic [PIX_W-1:0] do_q, do_d;
    logic             dso_q, dso_d;

    logic             accept;
    logic             winValid;
    logic [3:0]       kNext;
    logic [PIX_W-1:0] lb0Rd;
    logic [PIX_W-1:0] lb1Rd;

    assign PRDY     = (state_q == IDLE);
    assign accept   = PSI && (state_q == IDLE);
    assign winValid = (row_q >= RW'(2)) && (col_q >= CW'(2));
    assign kNext    = k_q + 4'd1;
    assign DO       = do_q;
    assign DSO      = dso_q;

    // lb0 holds the previous line, lb1 the one before; lb1 is fed from lb0's old value.
    med_line_buffer #(
        .DEPTH (WIDTH),
        .AW    (CW)
    ) u_lb0 (
        .clk_i  (CLK),
        .we_i   (accept),
        .addr_i (col_q),
        .din_i  (PI),
        .dout_o (lb0Rd)
    );

    med_line_buffer #(
        .DEPTH (WIDTH),
        .AW    (CW)
    ) u_lb1 (
        .clk_i  (CLK),
        .we_i   (accept),
        .addr_i (col_q),
        .din_i  (lb0Rd),
        .dout_o (lb1Rd)
    );

    // Raster position of the next pixel; wraps at end of line and end of frame.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (accept) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    // Shift the window left on acceptance and load the new right column.
    always_comb begin
        win_d = win_q;
        if (accept) begin
            win_d[0] = win_q[1];
            win_d[1] = win_q[2];
            win_d[2] = lb1Rd;
            win_d[3] = win_q[4];
            win_d[4] = win_q[5];
            win_d[5] = lb0Rd;
            win_d[6] = win_q[7];
            win_d[7] = win_q[8];
            win_d[8] = PI;
        end
    end

    // Window FSM and serialiser: w0 goes out on the accepting edge, so it is
    // taken from the freshly shifted window rather than the registered one.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        do_d    = do_q;
        dso_d   = dso_q;
        unique case (state_q)
            IDLE: begin
                if (accept && winValid) begin
                    state_d = SEND;
                    k_d     = 4'd0;
                    do_d    = win_d[0];
                    dso_d   = 1'b1;
                end
            end
            SEND: begin
                if (k_q == K_LAST) begin
                    state_d = WAIT;
                    k_d     = 4'd0;
                    do_d    = '0;
                    dso_d   = 1'b0;
                end else begin
                    k_d  = kNext;
                    do_d = win_q[kNext];
                end
            end
            WAIT: begin
                if (MDONE) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                k_d     = 4'd0;
                do_d    = '0;
                dso_d   = 1'b0;
            end
        endcase
    end

    // State, position, window and output registers; reset abandons any window.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            k_q     <= 4'd0;
            col_q   <= '0;
            row_q   <= '0;
            win_q   <= '0;
            do_q    <= '0;
            dso_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            col_q   <= col_d;
            row_q   <= row_d;
            win_q   <= win_d;
            do_q    <= do_d;
            dso_q   <= dso_d;
        end
    end

endmodule

// File: tb/tb_med_window.sv
// Self-checking bench for med_window. A frame model of the accepted pixels
// pushes each expected window to a queue at acceptance time; a monitor pops
// and compares samples while DSO is high and checks each burst length.
module tb_med_window;

    localparam int W   = 8;
    localparam int H   = 8;
    localparam int WIN = 9;

    logic       CLK;
    logic       nRST;
    logic [7:0] PI;
    logic       PSI;
    logic       PRDY;
    logic       MDONE;
    logic [7:0] DO;
    logic       DSO;

    logic autoMdone;
    logic manualMdone;
    logic autoDone;
    logic monitorOn;
    logic dsoPrev;

    int testCount;
    int failCount;
    int dsoRun;
    int windowsSeen;
    int doneTimer;

    int expQ[$];
    int img[H][W];
    int mRow;
    int mCol;

    assign MDONE = autoMdone | manualMdone;

    med_window #(
        .WIDTH  (W),
        .HEIGHT (H)
    ) dut (
        .CLK   (CLK),
        .nRST  (nRST),
        .PI    (PI),
        .PSI   (PSI),
        .PRDY  (PRDY),
        .MDONE (MDONE),
        .DO    (DO),
        .DSO   (DSO)
    );

    // Free-running 10 ns clock.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Hard stop in case something never completes.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Frame model: record the pixel, queue its window if interior, advance position.
    task automatic modelAccept(input int p);
        img[mRow][mCol] = p;
        if (mRow >= 2 && mCol >= 2) begin
            for (int r = mRow - 2; r <= mRow; r++) begin
                for (int c = mCol - 2; c <= mCol; c++) begin
                    expQ.push_back(img[r][c]);
                end
            end
        end
        if (mCol == W - 1) begin
            mCol = 0;
            mRow = (mRow == H - 1) ? 0 : mRow + 1;
        end else begin
            mCol++;
        end
    endtask

    // Offer one pixel; waits (bounded) for PRDY, returns at the negedge after acceptance.
    task automatic applyStimulus(input int p);
        int waitCycles;
        waitCycles = 0;
        PSI = 1'b1;
        PI  = 8'(p);
        while (PRDY !== 1'b1 && waitCycles < 200) begin
            @(negedge CLK);
            waitCycles++;
        end
        if (PRDY !== 1'b1) begin
            checkOutput("prdy_timeout", 0, 1);
            PSI = 1'b0;
        end else begin
            modelAccept(p);
            @(negedge CLK);
            PSI = 1'b0;
        end
    endtask

    // Wait (bounded) until the current burst is out and every expected sample consumed.
    task automatic waitWindowDone();
        int n;
        n = 0;
        while ((DSO === 1'b1 || expQ.size() != 0) && n < 100) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 100) begin
            checkOutput("window_timeout", 1, 0);
        end
        @(negedge CLK);
    endtask

    task automatic pulseMdone();
        manualMdone = 1'b1;
        @(negedge CLK);
        manualMdone = 1'b0;
    endtask

    // Monitor and automatic median-stage responder, both evaluated at the negedge.
    initial begin
        autoMdone = 1'b0;
        dsoPrev   = 1'b0;
        dsoRun    = 0;
        doneTimer = 0;
        forever begin
            @(negedge CLK);
            if (DSO === 1'b1) begin
                dsoRun++;
                if (monitorOn) begin
                    if (expQ.size() == 0) begin
                        checkOutput("unexpected_dso", 1, 0);
                    end else begin
                        checkOutput("do_sample", DO, expQ.pop_front());
                    end
                end
            end else begin
                if (dsoRun != 0 && monitorOn) begin
                    checkOutput("dso_length", dsoRun, WIN);
                    windowsSeen++;
                end
                dsoRun = 0;
            end
            autoMdone = 1'b0;
            if (autoDone) begin
                if (dsoPrev && DSO !== 1'b1) begin
                    doneTimer = 3;
                end else if (doneTimer > 0) begin
                    doneTimer--;
                    if (doneTimer == 0) begin
                        autoMdone = 1'b1;
                    end
                end
            end
            dsoPrev = (DSO === 1'b1);
        end
    end

    initial begin
        int prdyHigh;
        int dsoHigh;
        time t0;

        testCount   = 0;
        failCount   = 0;
        windowsSeen = 0;
        mRow        = 0;
        mCol        = 0;
        nRST        = 1'b0;
        PSI         = 1'b0;
        PI          = 8'd0;
        manualMdone = 1'b0;
        autoDone    = 1'b0;
        monitorOn   = 1'b1;

        // Reset and idle.
        repeat (3) @(negedge CLK);
        checkOutput("reset_dso", DSO, 0);
        checkOutput("reset_do", DO, 0);
        nRST = 1'b1;
        repeat (3) @(negedge CLK);
        checkOutput("idle_prdy", PRDY, 1);
        checkOutput("idle_dso", DSO, 0);
        checkOutput("idle_do", DO, 0);

        // Frame 1: ramp 8*row+col; first 18 pixels go in one per cycle.
        t0 = $time;
        for (int i = 0; i < 18; i++) begin
            applyStimulus(i);
        end
        checkOutput("first18_cycles", 32'(($time - t0) / 10), 18);
        checkOutput("first18_no_dso", DSO, 0);
        applyStimulus(18);
        checkOutput("w0_dso", DSO, 1);
        waitWindowDone();

        // Backpressure: pixel 19 offered while waiting on the median stage.
        PSI      = 1'b1;
        PI       = 8'd19;
        prdyHigh = 0;
        dsoHigh  = 0;
        repeat (20) begin
            @(negedge CLK);
            if (PRDY === 1'b1) prdyHigh++;
            if (DSO === 1'b1) dsoHigh++;
        end
        checkOutput("bp_prdy_low", prdyHigh, 0);
        checkOutput("bp_dso_low", dsoHigh, 0);
        pulseMdone();
        checkOutput("prdy_after_mdone", PRDY, 1);
        applyStimulus(19);
        waitWindowDone();
        pulseMdone();

        // MDONE in IDLE and during SEND must be ignored.
        pulseMdone();
        checkOutput("idle_mdone_prdy", PRDY, 1);
        applyStimulus(20);
        manualMdone = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        manualMdone = 1'b0;
        waitWindowDone();
        repeat (5) @(negedge CLK);
        checkOutput("wait_needs_mdone", PRDY, 0);
        pulseMdone();
        checkOutput("wait_released", PRDY, 1);

        // Rest of frame 1, including the line wraps, with an automatic responder.
        autoDone = 1'b1;
        for (int i = 21; i < W * H; i++) begin
            applyStimulus(i);
        end
        waitWindowDone();
        checkOutput("frame1_windows", windowsSeen, (W - 2) * (H - 2));

        // Frame 2: ramp + 100.
        windowsSeen = 0;
        for (int i = 0; i < W * H; i++) begin
            applyStimulus(i + 100);
        end
        waitWindowDone();
        checkOutput("frame2_windows", windowsSeen, (W - 2) * (H - 2));

        // Reset in the middle of a burst, after w3.
        for (int i = 0; i < 18; i++) begin
            applyStimulus(i + 50);
        end
        waitWindowDone();
        monitorOn = 1'b0;
        applyStimulus(68);
        checkOutput("mid_w0", DO, 50);
        @(negedge CLK);
        checkOutput("mid_w1", DO, 51);
        @(negedge CLK);
        checkOutput("mid_w2", DO, 52);
        @(negedge CLK);
        checkOutput("mid_w3", DO, 58);
        nRST = 1'b0;
        #1;
        checkOutput("async_rst_dso", DSO, 0);
        checkOutput("async_rst_do", DO, 0);
        checkOutput("async_rst_prdy", PRDY, 1);
        repeat (3) @(negedge CLK);
        nRST = 1'b1;
        expQ.delete();
        mRow      = 0;
        mCol      = 0;
        monitorOn = 1'b1;
        for (int i = 0; i < 18; i++) begin
            applyStimulus(i + 200);
        end
        checkOutput("post_reset_quiet", DSO, 0);
        applyStimulus(218);
        checkOutput("post_reset_window", DSO, 1);
        waitWindowDone();
        checkOutput("queue_drained", expQ.size(), 0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
